// File: rtl/mul_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mul_arbiter_pkg
//   Shared definitions for the shared-multiplier arbiter:
//     - MUL_W        : operand width of the shared Booth multiplier
//     - state_t      : arbiter FSM encoding (IDLE / CALC / DONE)
//     - booth_sel_t  : radix-4 Booth partial-product select
//     - booth_sel()  : recodes one overlapping 3-bit multiplier window
// ---------------------------------------------------------------------------
package mul_arbiter_pkg;

  localparam int MUL_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Radix-4 Booth digit in {-2,-1,0,+1,+2} as sign + magnitude selects.
  typedef struct packed {
    logic neg;
    logic two;
    logic one;
  } booth_sel_t;

  // Window is {b[2j+1], b[2j], b[2j-1]}.
  function automatic booth_sel_t booth_sel(input logic [2:0] win);
    booth_sel_t s;
    s = '0;
    case (win)
      3'b001, 3'b010: s = '{neg: 1'b0, two: 1'b0, one: 1'b1};
      3'b011:         s = '{neg: 1'b0, two: 1'b1, one: 1'b0};
      3'b100:         s = '{neg: 1'b1, two: 1'b1, one: 1'b0};
      3'b101, 3'b110: s = '{neg: 1'b1, two: 1'b0, one: 1'b1};
      default:        s = '0;  // 000 and 111 both encode digit 0
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mul_arbiter_multiply.sv
// ---------------------------------------------------------------------------
// multiply
//   Combinational WIDTH x WIDTH two's-complement multiplier, radix-4 Booth.
//   Produces the full 2*WIDTH product; no truncation or saturation.
//   This is a long combinational path: the owner is expected to hold the
//   inputs stable for several cycles before sampling o_p.
// Ports
//   i_a  in  WIDTH    multiplicand (signed)
//   i_b  in  WIDTH    multiplier (signed)
//   o_p  out 2*WIDTH  product (signed)
// ---------------------------------------------------------------------------
module multiply
  import mul_arbiter_pkg::*;
#(
  parameter int WIDTH = MUL_W
) (
  input  logic signed [WIDTH-1:0]   i_a,
  input  logic signed [WIDTH-1:0]   i_b,
  output logic signed [2*WIDTH-1:0] o_p
);

  // One Booth digit per pair of multiplier bits; odd widths get one extra
  // digit driven by the sign extension of i_b.
  localparam int NDIG = (WIDTH + 1) / 2;

  logic signed [2*WIDTH-1:0] w_a1;
  logic signed [2*WIDTH-1:0] w_a2;
  logic        [WIDTH+1:0]   w_bx;
  logic signed [2*WIDTH-1:0] w_pp;
  logic signed [2*WIDTH-1:0] w_acc;
  booth_sel_t                w_sel;

  assign w_a1 = {{WIDTH{i_a[WIDTH-1]}}, i_a};
  assign w_a2 = w_a1 <<< 1;
  // Bit 0 is the implicit b[-1]=0; the top bit repeats the sign.
  assign w_bx = {i_b[WIDTH-1], i_b, 1'b0};

  always_comb begin
    w_acc = '0;
    w_sel = '0;
    w_pp  = '0;
    for (int j = 0; j < NDIG; j++) begin
      w_sel = booth_sel(w_bx[2*j+2 -: 3]);
      if (w_sel.two) begin
        w_pp = w_a2;
      end else if (w_sel.one) begin
        w_pp = w_a1;
      end else begin
        w_pp = '0;
      end
      if (w_sel.neg) begin
        w_pp = -w_pp;
      end
      w_acc = w_acc + (w_pp <<< (2*j));
    end
  end

  assign o_p = w_acc;

endmodule

// File: rtl/mul_arbiter.sv
// ---------------------------------------------------------------------------
// mul_arbiter
//   Shares one combinational `multiply` between two requesters.
//   Round-robin arbitration in IDLE, operands latched on accept, the product
//   is allowed MUL_CYCLES cycles to settle in CALC, then registered and
//   returned as HI/LO over a valid/ready handshake to the owner in DONE.
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   req_valid  in   2      bit i: requester i presents operands
//   req_ready  out  2      bit i: requester i operands accepted this cycle
//   req_a0/b0  in   WIDTH  requester 0 operands (signed)
//   req_a1/b1  in   WIDTH  requester 1 operands (signed)
//   rsp_valid  out  2      bit i: result for requester i available
//   rsp_ready  in   2      bit i: requester i consumes the result
//   rsp_hi     out  WIDTH  product upper half
//   rsp_lo     out  WIDTH  product lower half
//   busy       out  1      high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int WIDTH      = MUL_W,
  parameter int MUL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [WIDTH-1:0] rsp_lo,
  output logic             busy
);

  // Counter only has to hold MUL_CYCLES-1; keep at least one bit.
  localparam int                CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(MUL_CYCLES - 1);

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_last_grant;
  logic                      r_owner;
  logic signed [WIDTH-1:0]   r_a;
  logic signed [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]          r_hi;
  logic [WIDTH-1:0]          r_lo;
  logic [1:0]                r_rsp_valid;

  logic                      w_any_req;
  logic                      w_grant;
  logic [1:0]                w_req_ready;
  logic                      w_accept;
  logic signed [2*WIDTH-1:0] w_prod;

  // -------------------------------------------------------------------------
  // Arbitration: a sole requester wins outright; on a tie the requester that
  // was not served last wins. last_grant resets to 1 so requester 0 wins the
  // first tie. Ready is masked during reset so nothing looks accepted while
  // rst_n is low.
  // -------------------------------------------------------------------------
  assign w_any_req = |req_valid;
  assign w_grant   = (&req_valid) ? ~r_last_grant : req_valid[1];

  always_comb begin
    w_req_ready = 2'b00;
    if (rst_n && (r_state == ST_IDLE) && w_any_req) begin
      w_req_ready = w_grant ? 2'b10 : 2'b01;
    end
  end

  assign w_accept = |(req_valid & w_req_ready);

  // The multiplier only ever sees the latched operands, so requester-side
  // changes after acceptance cannot disturb the settling product.
  multiply #(
    .WIDTH (WIDTH)
  ) u_multiply (
    .i_a (r_a),
    .i_b (r_b),
    .o_p (w_prod)
  );

  // -------------------------------------------------------------------------
  // FSM, counter, ownership, operand and result registers.
  // Operand registers are not cleared by reset: they are only consumed after
  // a fresh accept reloads them.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_rsp_valid  <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= w_grant ? $signed(req_a1) : $signed(req_a0);
            r_b     <= w_grant ? $signed(req_b1) : $signed(req_b0);
            r_owner <= w_grant;
            r_cnt   <= CNT_INIT;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_hi        <= w_prod[2*WIDTH-1:WIDTH];
            r_lo        <= w_prod[WIDTH-1:0];
            r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Only the owner's ready completes the response.
          if (rsp_ready[r_owner]) begin
            r_rsp_valid  <= 2'b00;
            r_last_grant <= r_owner;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 2'b00;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_hi    = r_hi;
  assign rsp_lo    = r_lo;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
module tb_mul_arbiter;

  localparam int WIDTH      = 32;
  localparam int MUL_CYCLES = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_hi, rsp_lo;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  int tb_last  = 1;

  always #5 clk = ~clk;

  mul_arbiter #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_hi    (rsp_hi),
    .rsp_lo    (rsp_lo),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit signed multiplication.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  // Reference arbitration: sole requester wins; tie goes to the one not served last.
  function automatic int model_grant(input logic [1:0] v, input int last);
    if (v == 2'b11) return 1 - last;
    return v[1] ? 1 : 0;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Runs one full transaction. Entered and left at posedge+1 with the FSM in IDLE.
  task automatic serve(input int exp_owner, input bit keep, input int stall);
    logic [63:0] exp_p;
    logic [1:0]  exp_bit;
    int          other;
    exp_bit = (exp_owner == 1) ? 2'b10 : 2'b01;
    other   = 1 - exp_owner;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("grant_ready", req_ready, exp_bit);
    exp_p = (exp_owner == 1) ? ref_prod(req_a1, req_b1) : ref_prod(req_a0, req_b0);
    @(posedge clk); #1;
    // Scramble the winner's operands: must not affect the result.
    if (exp_owner == 1) begin
      req_a1 = rnd_op(); req_b1 = rnd_op();
    end else begin
      req_a0 = rnd_op(); req_b0 = rnd_op();
    end
    if (!keep) req_valid[exp_owner] = 1'b0;
    repeat (MUL_CYCLES) begin
      @(negedge clk);
      chk("calc_busy", busy, 1);
      chk("calc_req_ready", req_ready, 0);
      chk("calc_rsp_valid", rsp_valid, 0);
      @(posedge clk); #1;
    end
    rsp_ready[other]     = 1'b1;  // non-owner ready must be ignored
    rsp_ready[exp_owner] = 1'b0;
    repeat (stall) begin
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, exp_bit);
      chk("stall_hi", rsp_hi, exp_p[63:32]);
      chk("stall_lo", rsp_lo, exp_p[31:0]);
      chk("stall_busy", busy, 1);
      chk("stall_req_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    rsp_ready[exp_owner] = 1'b1;
    @(negedge clk);
    chk("done_rsp_valid", rsp_valid, exp_bit);
    chk("done_hi", rsp_hi, exp_p[63:32]);
    chk("done_lo", rsp_lo, exp_p[31:0]);
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    chk("post_busy", busy, 0);
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_retain", {rsp_hi, rsp_lo}, exp_p);
    tb_last = exp_owner;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req_a0    = $urandom; req_b0 = $urandom;
    req_a1    = $urandom; req_b1 = $urandom;

    // Reset with both requesters valid.
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_hi", rsp_hi, 0);
      chk("rst_lo", rsp_lo, 0);
      chk("rst_busy", busy, 0);
    end
    tb_last = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Contention from reset: order 0,1,0,1; first one back-pressured 5 cycles.
    serve(0, 1'b1, 5);
    serve(1, 1'b1, 0);
    serve(0, 1'b0, 1);
    serve(1, 1'b0, 0);

    // Single op 7 * -3.
    req_a0 = 32'd7; req_b0 = 32'hFFFF_FFFD; req_valid = 2'b01;
    serve(0, 1'b0, 0);
    chk("k7xm3_hi", rsp_hi, 32'hFFFF_FFFF);
    chk("k7xm3_lo", rsp_lo, 32'hFFFF_FFEB);

    // Corners.
    req_a1 = 32'h8000_0000; req_b1 = 32'h8000_0000; req_valid = 2'b10;
    serve(1, 1'b0, 0);
    chk("min_sq_hi", rsp_hi, 32'h4000_0000);
    chk("min_sq_lo", rsp_lo, 32'h0000_0000);
    req_a0 = 32'hFFFF_FFFF; req_b0 = 32'd1; req_valid = 2'b01;
    serve(0, 1'b0, 0);
    chk("m1x1_hi", rsp_hi, 32'hFFFF_FFFF);
    chk("m1x1_lo", rsp_lo, 32'hFFFF_FFFF);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 16; i++) begin
      logic [1:0] v;
      v      = 2'($urandom_range(1, 3));
      req_a0 = rnd_op(); req_b0 = rnd_op();
      req_a1 = rnd_op(); req_b1 = rnd_op();
      req_valid = v;
      serve(model_grant(v, tb_last), 1'b0, $urandom_range(0, 2));
    end

    // Reset in the middle of CALC.
    req_valid = 2'b00;
    req_a0 = 32'h1234_5678; req_b0 = 32'h0000_0010; req_valid = 2'b01;
    @(negedge clk);
    chk("mid_accept", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("mid_calc_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tb_last = 1;
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_hi", rsp_hi, 0);
    chk("mid_lo", rsp_lo, 0);
    repeat (MUL_CYCLES + 1) begin
      @(negedge clk);
      chk("mid_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    req_a0 = 32'hFFFF_FF9C; req_b0 = 32'd250;
    req_a1 = 32'd40000;     req_b1 = 32'hFFFF_0000;
    req_valid = 2'b11;
    serve(model_grant(2'b11, tb_last), 1'b0, 0);
    chk("post_rst_owner0", {rsp_hi, rsp_lo}, 64'hFFFF_FFFF_FFFF_9E58);
    serve(model_grant(req_valid, tb_last), 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
